// File: rtl/eva_ahb_mst_arb.sv
// Round-robin arbiter sharing one AHB-lite master port between NREQ request/response clients.
// Each granted request becomes a single NONSEQ transfer, or a local error if misaligned.
module eva_ahb_mst_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                 hclk,
  input  logic                 hrest_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_write,
  input  logic [3*NREQ-1:0]    req_size,
  input  logic [AW*NREQ-1:0]   req_addr,
  input  logic [DW*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      rsp_valid,
  output logic                 rsp_err,
  output logic [DW-1:0]        rsp_rdata,
  output logic [2:0]           cur_id,
  output logic                 busy,
  output logic [1:0]           htrans,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  output logic [AW-1:0]        haddr,
  output logic [DW-1:0]        hwdata,
  output logic [2:0]           hburst,
  output logic [3:0]           hprot,
  input  logic                 hready,
  input  logic [1:0]           hresp,
  input  logic [DW-1:0]        hrdata
);

  localparam logic [2:0] SIZE_MAX   = 3'($clog2(DW/8));
  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_LERR} state_t;

  state_t          state, state_d;
  logic [2:0]      rr_ptr;
  logic            any_req;
  logic [2:0]      gnt;
  int              idx;
  logic [2:0]      sel_size;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            sel_write;
  logic [AW-1:0]   align_mask;
  logic            misaligned;
  logic [DW-1:0]   wdata_q;

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] i);
    return NREQ'(1) << i;
  endfunction

  assign hburst = 3'b000;
  assign hprot  = 4'b0011;

  // Search starts just past the last granted client, so every pending client is served once per round.
  always_comb begin
    any_req = 1'b0;
    gnt     = rr_ptr;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        gnt     = 3'(idx);
      end
    end
  end

  assign sel_size   = req_size[int'(gnt)*3 +: 3];
  assign sel_addr   = req_addr[int'(gnt)*AW +: AW];
  assign sel_wdata  = req_wdata[int'(gnt)*DW +: DW];
  assign sel_write  = req_write[gnt];
  assign align_mask = ~({AW{1'b1}} << sel_size);
  assign misaligned = (sel_size > SIZE_MAX) || ((sel_addr & align_mask) != '0);

  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (any_req) state_d = misaligned ? S_LERR : S_ADDR;
      S_ADDR: if (hready)  state_d = S_DATA;
      S_DATA: if (hready)  state_d = S_IDLE;
      S_LERR:              state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      cur_id    <= '0;
      busy      <= 1'b0;
      rr_ptr    <= 3'(NREQ-1);
      htrans    <= TR_IDLE;
      hwrite    <= 1'b0;
      hsize     <= '0;
      haddr     <= '0;
      hwdata    <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            req_ready <= onehot(gnt);
            cur_id    <= gnt;
            busy      <= 1'b1;
            rr_ptr    <= gnt;
            if (!misaligned) begin
              htrans <= TR_NONSEQ;
              haddr  <= sel_addr;
              hwrite <= sel_write;
              hsize  <= sel_size;
            end
          end
        end
        S_ADDR: begin
          if (hready) begin
            htrans <= TR_IDLE;
            if (hwrite) hwdata <= wdata_q;
          end
        end
        S_DATA: begin
          // The first cycle of a two-cycle ERROR has hready low and is simply waited through.
          if (hready) begin
            rsp_valid <= onehot(cur_id);
            rsp_err   <= (hresp == RESP_ERROR);
            rsp_rdata <= hwrite ? '0 : hrdata;
            busy      <= 1'b0;
          end
        end
        S_LERR: begin
          rsp_valid <= onehot(cur_id);
          rsp_err   <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (state == S_IDLE && any_req) wdata_q <= sel_wdata;
  end

endmodule

// File: tb/tb_eva_ahb_mst_arb.sv
// Directed bench for eva_ahb_mst_arb: behavioural AHB slave, response scoreboard and grant-order checks.
`timescale 1ns/1ps
module tb_eva_ahb_mst_arb;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic                hclk = 1'b0;
  logic                hrest_n;
  logic [NREQ-1:0]     req_valid, req_ready, req_write, rsp_valid;
  logic [3*NREQ-1:0]   req_size;
  logic [AW*NREQ-1:0]  req_addr;
  logic [DW*NREQ-1:0]  req_wdata;
  logic                rsp_err, busy, hwrite, hready;
  logic [DW-1:0]       rsp_rdata, hwdata, hrdata;
  logic [2:0]          cur_id, hsize, hburst;
  logic [1:0]          htrans, hresp;
  logic [AW-1:0]       haddr;
  logic [3:0]          hprot;

  eva_ahb_mst_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .hclk(hclk), .hrest_n(hrest_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .cur_id(cur_id), .busy(busy),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hburst(hburst), .hprot(hprot), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    int          extra;   // data-phase wait states; -1 = latency not checked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   base_lat = -1;
  int   ready_cyc[NREQ];
  bit   saw_nonseq = 1'b0;

  int          slv_wait  = 0;
  bit          slv_err   = 1'b0;
  bit          slv_xor   = 1'b0;
  logic [31:0] slv_rdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2id(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_req(input int id, input logic wr, input logic [2:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
    req_write[id]         = wr;
    req_size[id*3 +: 3]   = sz;
    req_addr[id*AW +: AW] = ad;
    req_wdata[id*DW +: DW] = wd;
    req_valid[id]         = 1'b1;
  endtask

  task automatic issue(input int id, input logic wr, input logic [2:0] sz,
                       input logic [31:0] ad, input logic [31:0] wd);
    set_req(id, wr, sz, ad, wd);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (req_ready[id]) break;
    end
    check("req_ready_grant", 64'(req_ready), 64'(1) << id);
    req_valid[id] = 1'b0;
  endtask

  task automatic collect(input int n, output int ids[8], output int cs[8]);
    int got;
    got = 0;
    for (int i = 0; i < 8; i++) begin ids[i] = -1; cs[i] = 0; end
    for (int k = 0; k < 40*n && got < n; k++) begin
      tick();
      if (req_ready != '0) begin
        ids[got] = oh2id(req_ready);
        cs[got]  = cyc;
        got++;
      end
    end
    check("grant_count", 64'(got), 64'(n));
  endtask

  // AHB slave: zero-wait address phase, programmable data-phase waits and error.
  initial begin
    hready = 1'b1; hresp = 2'b00; hrdata = '0;
    forever begin
      tick();
      if (hrest_n && htrans == 2'b10 && hready) begin
        tick();
        for (int w = 0; w < slv_wait; w++) begin
          hready = 1'b0;
          hresp  = (slv_err && w == slv_wait-1) ? 2'b01 : 2'b00;
          tick();
        end
        hready = 1'b1;
        hresp  = slv_err ? 2'b01 : 2'b00;
        hrdata = slv_xor ? (slv_rdata ^ haddr) : slv_rdata;
        tick();
        hresp  = 2'b00;
        hrdata = '0;
      end
    end
  end

  // Response monitor and scoreboard.
  initial begin : mon
    exp_t            e;
    int              lat;
    logic [NREQ-1:0] prev_rsp;
    prev_rsp = '0;
    forever begin
      @(negedge hclk);
      if (htrans == 2'b10) saw_nonseq = 1'b1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) ready_cyc[i] = cyc;
      if (prev_rsp != '0)
        check("rsp_clear_next", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
      if (rsp_valid != '0) begin
        check("rsp_expected", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
          e   = sb.pop_front();
          lat = cyc - ready_cyc[e.id];
          check("rsp_onehot", 64'(rsp_valid), 64'(1) << e.id);
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          if (e.extra == 0 && base_lat < 0) begin
            base_lat = lat;
            check("rsp_min_latency", 64'(lat >= 2), 64'(1));
          end else if (e.extra >= 0 && base_lat >= 0) begin
            check("rsp_latency", 64'(lat), 64'(base_lat + e.extra));
          end
        end
      end
      prev_rsp = rsp_valid;
    end
  end

  initial begin : seq
    int ids[8];
    int cs[8];
    int exp_ids[6];
    req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    hrest_n = 1'b0;
    repeat (3) tick();
    check("rst_htrans", 64'(htrans), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    check("rst_addr_ctrl", 64'({haddr, hwrite, hsize}), 64'(0));
    check("rst_hwdata", 64'(hwdata), 64'(0));
    check("rst_cur_id", 64'(cur_id), 64'(0));
    check("tie_hburst", 64'(hburst), 64'(0));
    check("tie_hprot", 64'(hprot), 64'(4'b0011));
    hrest_n = 1'b1;
    tick();

    // Single zero-wait write from client 1.
    sb.push_back('{1, 1'b0, 32'h0, 0});
    issue(1, 1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF);
    check("w_htrans_nonseq", 64'(htrans), 64'(2'b10));
    check("w_haddr", 64'(haddr), 64'(32'h1004));
    check("w_hwrite", 64'(hwrite), 64'(1));
    check("w_hsize", 64'(hsize), 64'(2));
    check("w_busy", 64'(busy), 64'(1));
    check("w_cur_id", 64'(cur_id), 64'(1));
    tick();
    check("w_htrans_idle", 64'(htrans), 64'(0));
    check("w_hwdata", 64'(hwdata), 64'(32'hDEAD_BEEF));
    tick();
    check("w_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    check("w_busy_clear", 64'(busy), 64'(0));
    repeat (2) tick();

    // Read with three data-phase wait states.
    slv_wait = 3; slv_rdata = 32'h1234_5678;
    sb.push_back('{2, 1'b0, 32'h1234_5678, 3});
    issue(2, 1'b0, 3'd2, 32'h0000_2000, 32'h0);
    check("r_htrans_nonseq", 64'(htrans), 64'(2'b10));
    check("r_hwrite", 64'(hwrite), 64'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("r_haddr_held", 64'(haddr), 64'(32'h2000));
      check("r_busy_wait", 64'(busy), 64'(1));
    end
    repeat (3) tick();
    check("r_hwdata_kept", 64'(hwdata), 64'(32'hDEAD_BEEF));

    // Two-cycle ERROR on a write, then a clean read, then a single-cycle ERROR.
    slv_wait = 1; slv_err = 1'b1;
    sb.push_back('{0, 1'b1, 32'h0, 1});
    issue(0, 1'b1, 3'd2, 32'h0000_3000, 32'hCAFE_F00D);
    repeat (4) tick();
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h55AA_55AA;
    sb.push_back('{0, 1'b0, 32'h55AA_55AA, 0});
    issue(0, 1'b0, 3'd2, 32'h0000_3004, 32'h0);
    repeat (4) tick();
    slv_err = 1'b1; slv_rdata = 32'h0BAD_0BAD;
    sb.push_back('{3, 1'b1, 32'h0BAD_0BAD, 0});
    issue(3, 1'b0, 3'd1, 32'h0000_3002, 32'h0);
    repeat (4) tick();
    slv_err = 1'b0;
    check("e_hwdata", 64'(hwdata), 64'(32'hCAFE_F00D));

    // Local errors: misaligned word, oversize access, then a sole misaligned requester.
    saw_nonseq = 1'b0;
    sb.push_back('{1, 1'b1, 32'h0, -1});
    issue(1, 1'b1, 3'd2, 32'h0000_1002, 32'h1111_1111);
    repeat (3) tick();
    sb.push_back('{3, 1'b1, 32'h0, -1});
    issue(3, 1'b0, 3'd3, 32'h0000_1000, 32'h0);
    repeat (3) tick();
    sb.push_back('{0, 1'b1, 32'h0, -1});
    sb.push_back('{0, 1'b1, 32'h0, -1});
    set_req(0, 1'b0, 3'd2, 32'h0000_0001, 32'h0);
    collect(2, ids, cs);
    req_valid = '0;
    check("lerr_ids", 64'({ids[0][3:0], ids[1][3:0]}), 64'(8'h00));
    check("lerr_spacing", 64'(cs[1] - cs[0]), 64'(2));
    repeat (3) tick();
    check("lerr_no_nonseq", 64'(saw_nonseq), 64'(0));
    check("lerr_hwdata", 64'(hwdata), 64'(32'hCAFE_F00D));

    // Reset during the data phase abandons the transfer silently.
    slv_wait = 4;
    issue(2, 1'b0, 3'd2, 32'h0000_4000, 32'h0);
    tick();
    #2;
    hrest_n = 1'b0;
    #1;
    check("mid_rst_htrans", 64'(htrans), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    check("mid_rst_haddr", 64'(haddr), 64'(0));
    repeat (8) tick();
    hrest_n = 1'b1;
    repeat (3) tick();

    // All clients requesting continuously from reset.
    slv_wait = 0; slv_xor = 1'b1; slv_rdata = 32'hA000_0000;
    exp_ids = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++)
      sb.push_back('{exp_ids[i], 1'b0, 32'hA000_0000 ^ (32'h100 * (exp_ids[i] + 1)), 0});
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 3'd2, 32'h100 * (i + 1), 32'h0);
    collect(6, ids, cs);
    req_valid = '0;
    for (int i = 0; i < 6; i++) check("rr_order", 64'(ids[i]), 64'(exp_ids[i]));
    for (int i = 1; i < 6; i++) check("rr_spacing", 64'(cs[i] - cs[i-1]), 64'(3));
    repeat (4) tick();

    // Sole requester served back-to-back, then two pending clients alternate.
    slv_xor = 1'b0; slv_rdata = 32'h0000_0077;
    for (int i = 0; i < 3; i++) sb.push_back('{2, 1'b0, 32'h77, 0});
    set_req(2, 1'b0, 3'd0, 32'h0000_5001, 32'h0);
    collect(3, ids, cs);
    req_valid = '0;
    check("sole_ids", 64'({ids[0][3:0], ids[1][3:0], ids[2][3:0]}), 64'(12'h222));
    check("sole_spacing", 64'(cs[2] - cs[0]), 64'(6));
    repeat (4) tick();
    sb.push_back('{3, 1'b0, 32'h77, 0});
    sb.push_back('{1, 1'b0, 32'h77, 0});
    sb.push_back('{3, 1'b0, 32'h77, 0});
    set_req(1, 1'b0, 3'd2, 32'h0000_6000, 32'h0);
    set_req(3, 1'b0, 3'd2, 32'h0000_7000, 32'h0);
    collect(3, ids, cs);
    req_valid = '0;
    check("pair_ids", 64'({ids[0][3:0], ids[1][3:0], ids[2][3:0]}), 64'(12'h313));

    for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
    check("sb_drained", 64'(sb.size()), 64'(0));
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
